// File: rtl/out_display_pkg.sv
// Shared constants for the decimal 7-segment output display: digit codes,
// segment patterns, FSM encodings and the digit-to-segment decoder.
package out_display_pkg;

    localparam int unsigned BCD_W = 12;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Segment order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_pattern(input logic [3:0] dig);
        case (dig)
            4'd0:      return SEG_0;
            4'd1:      return SEG_1;
            4'd2:      return SEG_2;
            4'd3:      return SEG_3;
            4'd4:      return SEG_4;
            4'd5:      return SEG_5;
            4'd6:      return SEG_6;
            4'd7:      return SEG_7;
            4'd8:      return SEG_8;
            4'd9:      return SEG_9;
            DIG_MINUS: return SEG_MINUS;
            default:   return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/out_display_bin2bcd.sv
// Sequential double-dabble converter: DATA_WIDTH shift steps, the first one
// folded into the load cycle, then a one-cycle o_done pulse with o_bcd valid.
module out_display_bin2bcd
    import out_display_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_mag,
    output logic                  o_done,
    output logic [BCD_W-1:0]      o_bcd
);

    localparam int unsigned SR_W  = BCD_W + DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // One double-dabble step: correct each BCD nibble, then shift left
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int i = 0; i < 3; i++) begin
            if (t[DATA_WIDTH + 4*i +: 4] >= 4'd5) begin
                t[DATA_WIDTH + 4*i +: 4] = t[DATA_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (i_start) begin
            sr_d  = dabble({BCD_W'(0), i_mag});
            cnt_d = CNT_W'(DATA_WIDTH - 1);
        end else if (cnt_q != '0) begin
            sr_d   = dabble(sr_q);
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign o_done = done_q;
    assign o_bcd  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/out_display.sv
// Shows the CPU out-register in decimal on a 4-digit multiplexed 7-segment
// display, unsigned or two's complement, with leading-zero blanking.
module out_display
    import out_display_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_signed,
    output logic [6:0]            o_seg,
    output logic [3:0]            o_an,
    output logic                  o_busy
);

    localparam int unsigned SNAP_W = DATA_WIDTH + 1;
    localparam int unsigned RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [1:0]            state_q, state_d;
    logic [SNAP_W-1:0]     snap_q, snap_d;
    logic [3:0][3:0]       shown_q, shown_d;
    logic                  busy_q, busy_d;
    logic [RCNT_W-1:0]     rcnt_q, rcnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic [SNAP_W-1:0]     live_c;
    logic                  start_c;
    logic                  snap_neg_c;
    logic [DATA_WIDTH-1:0] mag_c;
    logic                  conv_done;
    logic [BCD_W-1:0]      bcd;

    assign live_c     = {i_signed, i_data};
    assign snap_neg_c = snap_q[DATA_WIDTH] & snap_q[DATA_WIDTH-1];

    // Negation mod 2^DATA_WIDTH is exact: the most negative value still fits unsigned
    assign mag_c = (i_signed && i_data[DATA_WIDTH-1]) ? (~i_data + DATA_WIDTH'(1)) : i_data;

    out_display_bin2bcd #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bin2bcd (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (start_c),
        .i_mag   (mag_c),
        .o_done  (conv_done),
        .o_bcd   (bcd)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        shown_d = shown_q;
        start_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (live_c != snap_q) begin
                    snap_d  = live_c;
                    start_c = 1'b1;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // All four digits change together so the scan never shows a mix
                shown_d[0] = bcd[3:0];
                shown_d[1] = (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? DIG_BLANK : bcd[7:4];
                shown_d[2] = (bcd[11:8] == 4'd0) ? DIG_BLANK : bcd[11:8];
                shown_d[3] = snap_neg_c ? DIG_MINUS : DIG_BLANK;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CONVERT);

        // Free-running digit scan, independent of the conversion FSM
        rcnt_d = rcnt_q + RCNT_W'(1);
        idx_d  = idx_q;
        if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
            rcnt_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        an_d  = 4'b0001 << idx_q;
        seg_d = seg_pattern(shown_q[idx_q]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            shown_q <= {DIG_BLANK, DIG_BLANK, DIG_BLANK, 4'd0};
            busy_q  <= 1'b0;
            rcnt_q  <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b0001;
            seg_q   <= SEG_0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            shown_q <= shown_d;
            busy_q  <= busy_d;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign o_seg  = seg_q;
    assign o_an   = an_q;
    assign o_busy = busy_q;

endmodule
